display_scan_mux: RTL and testbench

Time-multiplexes NUM_DIGITS packed 4-bit hex values onto one shared 4-bit nibble bus and one set of active-low digit enables. It sits directly upstream of the combinational hex-to-seven-segment decoder: `bin_out` drives the decoder's `bin` input, and `anode_n` drives the common-anode digit transistors. New values load atomically at frame boundaries, so a display update never tears. A dead-time (blank) interval between digits suppresses ghosting.

---
 rtl/display_scan_mux.sv | 64 ++++++
 tb/tb_display_scan_mux.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexes packed hex digits onto one nibble bus with blanking between digits
module display_scan_mux #(
  parameter int NUM_DIGITS = 2,
  parameter int ON_CYCLES = 24000,
  parameter int BLANK_CYCLES = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic [3:0]              bin_out,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    frame_done
);
  localparam int MAX_CYCLES = ON_CYCLES > BLANK_CYCLES ? ON_CYCLES : BLANK_CYCLES;
  localparam int CW = MAX_CYCLES > 1 ? $clog2(MAX_CYCLES) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] ON_LAST = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  typedef enum logic {BLANK, ON} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [IW-1:0] idx, idx_nx;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_nx, display, display_nx;
  logic pending, pending_nx, last, frame_done_nx;
  logic [3:0] bin_nx;
  logic [NUM_DIGITS-1:0] anode_nx;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BLANK;
      cnt <= '0;
      idx <= '0;
      shadow <= '0;
      display <= '0;
      pending <= 1'b0;
      bin_out <= 4'h0;
      anode_n <= '1;
      frame_done <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      idx <= idx_nx;
      shadow <= shadow_nx;
      display <= display_nx;
      pending <= pending_nx;
      bin_out <= bin_nx;
      anode_n <= anode_nx;
      frame_done <= frame_done_nx;
    end
  end
  always_comb begin
    last = (state == ON) ? (cnt == ON_LAST) : (cnt == BLANK_LAST);
    state_nx = last ? (state == ON ? BLANK : ON) : state;
    cnt_nx = last ? '0 : cnt + 1'b1;
    idx_nx = (state == ON && last) ? (idx == IDX_LAST ? '0 : idx + 1'b1) : idx;
    display_nx = frame_done ? (load ? digits_in : pending ? shadow : display) : display;
    shadow_nx = (load && !frame_done) ? digits_in : shadow;
    pending_nx = !frame_done && (load || pending);
    anode_nx = (state_nx == ON) ? ~(NUM_DIGITS'(1) << idx_nx) : '1;
    bin_nx = display_nx[4*idx_nx +: 4];
    frame_done_nx = state_nx == ON && cnt_nx == ON_LAST && idx_nx == IDX_LAST;
  end
endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: randomized and directed checks of display_scan_mux against a cycle-count reference model
module tb_display_scan_mux;
  localparam int ON = 4;
  localparam int BL = 2;
  localparam int SLOT = ON + BL;
  localparam int FRAME = 2 * SLOT;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load = 1'b0;
  logic [7:0] digits_in = 8'h00;
  logic [3:0] bin_out;
  logic [1:0] anode_n;
  logic frame_done;
  int checks = 0;
  int errors = 0;
  int t;
  logic [7:0] disp, last_val;
  bit has;
  display_scan_mux #(.NUM_DIGITS(2), .ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
    .bin_out(bin_out), .anode_n(anode_n), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  function automatic logic [1:0] exp_anode();
    int d = (t % FRAME) / SLOT;
    return (t % SLOT) >= BL ? (d == 0 ? 2'b10 : 2'b01) : 2'b11;
  endfunction
  function automatic logic [3:0] exp_bin();
    int d = (t % FRAME) / SLOT;
    return d == 0 ? disp[3:0] : disp[7:4];
  endfunction
  function automatic logic exp_fd();
    return (t % FRAME) == FRAME - 1;
  endfunction
  task automatic tick();
    if (load) begin
      last_val = digits_in;
      has = 1'b1;
    end
    if ((t % FRAME) == FRAME - 1) begin
      if (has) disp = last_val;
      has = 1'b0;
    end
    t++;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    load = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    t = 0;
    disp = 8'h00;
    has = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    checks += 3;
    if (anode_n !== 2'b11) begin errors++; $display("FAIL reset anode_n got %b exp 11", anode_n); end
    if (bin_out !== 4'h0) begin errors++; $display("FAIL reset bin_out got %h exp 0", bin_out); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset frame_done got %b exp 0", frame_done); end
  endtask
  task automatic test_first_frame();
    for (int c = 0; c < 2 * FRAME; c++) begin
      load = (c == 0);
      digits_in = 8'h3A;
      checks += 3;
      if (anode_n !== exp_anode()) begin errors++; $display("FAIL first_frame anode_n t=%0d got %b exp %b", t, anode_n, exp_anode()); end
      if (bin_out !== exp_bin()) begin errors++; $display("FAIL first_frame bin_out t=%0d got %h exp %h", t, bin_out, exp_bin()); end
      if (frame_done !== exp_fd()) begin errors++; $display("FAIL first_frame frame_done t=%0d got %b exp %b", t, frame_done, exp_fd()); end
      if (c == 12 || c == 18) begin
        checks++;
        if (bin_out !== (c == 12 ? 4'hA : 4'h3)) begin errors++; $display("FAIL first_frame new_value c=%0d got %h", c, bin_out); end
      end
      tick();
    end
    load = 1'b0;
  endtask
  task automatic test_multi_load();
    for (int c = 0; c < 2 * FRAME; c++) begin
      load = (c == 3) || (c == 7);
      digits_in = (c == 3) ? 8'h12 : 8'h34;
      checks += 3;
      if (anode_n !== exp_anode()) begin errors++; $display("FAIL multi_load anode_n t=%0d got %b exp %b", t, anode_n, exp_anode()); end
      if (bin_out !== exp_bin()) begin errors++; $display("FAIL multi_load bin_out t=%0d got %h exp %h", t, bin_out, exp_bin()); end
      if (frame_done !== exp_fd()) begin errors++; $display("FAIL multi_load frame_done t=%0d got %b exp %b", t, frame_done, exp_fd()); end
      if (c == 12 || c == 18) begin
        checks++;
        if (bin_out !== (c == 12 ? 4'h4 : 4'h3)) begin errors++; $display("FAIL multi_load last_wins c=%0d got %h", c, bin_out); end
      end
      tick();
    end
    load = 1'b0;
  endtask
  task automatic test_boundary_load();
    for (int c = 0; c < 2 * FRAME; c++) begin
      load = (c == 5) || (c == 11);
      digits_in = (c == 5) ? 8'h34 : 8'h56;
      checks += 3;
      if (anode_n !== exp_anode()) begin errors++; $display("FAIL boundary_load anode_n t=%0d got %b exp %b", t, anode_n, exp_anode()); end
      if (bin_out !== exp_bin()) begin errors++; $display("FAIL boundary_load bin_out t=%0d got %h exp %h", t, bin_out, exp_bin()); end
      if (frame_done !== exp_fd()) begin errors++; $display("FAIL boundary_load frame_done t=%0d got %b exp %b", t, frame_done, exp_fd()); end
      if (c >= 12) begin
        checks++;
        if (bin_out !== (c < 18 ? 4'h6 : 4'h5)) begin errors++; $display("FAIL boundary_load bypass c=%0d got %h", c, bin_out); end
      end
      tick();
    end
    load = 1'b0;
  endtask
  task automatic test_reset_mid();
    for (int c = 0; c < 9; c++) begin
      load = (c == 4);
      digits_in = 8'h77;
      checks++;
      if (bin_out !== exp_bin()) begin errors++; $display("FAIL reset_mid pre bin_out t=%0d got %h exp %h", t, bin_out, exp_bin()); end
      tick();
    end
    load = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks += 3;
    if (anode_n !== 2'b11) begin errors++; $display("FAIL reset_mid anode_n got %b exp 11", anode_n); end
    if (bin_out !== 4'h0) begin errors++; $display("FAIL reset_mid bin_out got %h exp 0", bin_out); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_mid frame_done got %b exp 0", frame_done); end
    t = 0;
    disp = 8'h00;
    has = 1'b0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      checks += 3;
      if (anode_n !== exp_anode()) begin errors++; $display("FAIL reset_mid anode_n t=%0d got %b exp %b", t, anode_n, exp_anode()); end
      if (bin_out !== 4'h0) begin errors++; $display("FAIL reset_mid zeros t=%0d got %h exp 0", t, bin_out); end
      if (frame_done !== exp_fd()) begin errors++; $display("FAIL reset_mid frame_done t=%0d got %b exp %b", t, frame_done, exp_fd()); end
      tick();
    end
  endtask
  task automatic test_random();
    int last_fd = -1;
    for (int c = 0; c < 1000; c++) begin
      load = ($urandom_range(0, 7) == 0);
      digits_in = 8'($urandom);
      checks += 4;
      if (anode_n === 2'b00) begin errors++; $display("FAIL random two_anodes t=%0d got %b", t, anode_n); end
      if (anode_n !== exp_anode()) begin errors++; $display("FAIL random anode_n t=%0d got %b exp %b", t, anode_n, exp_anode()); end
      if (bin_out !== exp_bin()) begin errors++; $display("FAIL random bin_out t=%0d got %h exp %h", t, bin_out, exp_bin()); end
      if (frame_done !== exp_fd()) begin errors++; $display("FAIL random frame_done t=%0d got %b exp %b", t, frame_done, exp_fd()); end
      if (frame_done === 1'b1) begin
        if (last_fd >= 0) begin
          checks++;
          if (c - last_fd != FRAME) begin errors++; $display("FAIL random fd_period got %0d exp %0d", c - last_fd, FRAME); end
        end
        last_fd = c;
      end
      tick();
    end
    load = 1'b0;
  endtask
  initial begin
    test_reset();
    test_first_frame();
    test_multi_load();
    test_boundary_load();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
